unary_ift_rr_scheduler: RTL and testbench

- Shares one unary-operator evaluation datapath (not, pos, neg, reduce_and/or/xor/xnor, logic_not) among NUM_REQ requesters.
- Selection is round-robin; every operand carries a 32-bit taint tag that is propagated to the result.
- Sits between requesting agents and the downstream consumer, with one registered output stage and a valid/ready handshake on both sides.

---
 rtl/unary_ift_rr_scheduler_pkg.sv | 21 ++
 rtl/unary_ift_rr_scheduler_eval.sv | 41 ++++
 rtl/unary_ift_rr_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_unary_ift_rr_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/unary_ift_rr_scheduler_pkg.sv
// Shared definitions for the unary IFT round-robin scheduler: opcodes, FSM states, widths.
// The optional control-flow taint feature is selected with UNARY_IFT_SCHED_TAINT_CTRL_EN.
package unary_ift_rr_scheduler_pkg;

  localparam int TAINT_W_DEF = 32;

  localparam logic [2:0] OP_NOT         = 3'd0;
  localparam logic [2:0] OP_POS         = 3'd1;
  localparam logic [2:0] OP_NEG         = 3'd2;
  localparam logic [2:0] OP_REDUCE_AND  = 3'd3;
  localparam logic [2:0] OP_REDUCE_OR   = 3'd4;
  localparam logic [2:0] OP_REDUCE_XOR  = 3'd5;
  localparam logic [2:0] OP_REDUCE_XNOR = 3'd6;
  localparam logic [2:0] OP_LOGIC_NOT   = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/unary_ift_rr_scheduler_eval.sv
// Combinational unary-operator evaluation with taint propagation for one operand.
// Result taint is the operand tag ORed with an externally supplied control-flow tag.
module unary_ift_eval
  import unary_ift_rr_scheduler_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TAINT_W = TAINT_W_DEF
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [TAINT_W-1:0] a_t,
  input  logic [TAINT_W-1:0] ctrl_t,
  input  logic [2:0]         op,
  output logic [DATA_W-1:0]  y,
  output logic [TAINT_W-1:0] y_t
);

  logic bit_res;

  always_comb begin
    bit_res = 1'b0;
    y       = '0;
    case (op)
      OP_NOT:         y = ~a;
      OP_POS:         y = a;
      OP_NEG:         y = -a;
      OP_REDUCE_AND:  bit_res = &a;
      OP_REDUCE_OR:   bit_res = |a;
      OP_REDUCE_XOR:  bit_res = ^a;
      OP_REDUCE_XNOR: bit_res = ~^a;
      OP_LOGIC_NOT:   bit_res = ~|a;
      default:        y = '0;
    endcase
    // Single-bit results are zero-extended to the full data width.
    if (op >= OP_REDUCE_AND) begin
      y = {{(DATA_W-1){1'b0}}, bit_res};
    end
  end

  assign y_t = a_t | ctrl_t;

endmodule

// File: rtl/unary_ift_rr_scheduler.sv
// Round-robin scheduler sharing one unary evaluation datapath among NUM_REQ requesters,
// with a single registered output stage. Define UNARY_IFT_SCHED_TAINT_CTRL_EN for ctrl_taint.
module unary_ift_rr_scheduler
  import unary_ift_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TAINT_W = TAINT_W_DEF,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*TAINT_W-1:0] req_a_t,
  input  logic [NUM_REQ*3-1:0]       req_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [TAINT_W-1:0]         out_data_t,
  output logic [ID_W-1:0]            out_id,
  output logic [2:0]                 out_op
`ifdef UNARY_IFT_SCHED_TAINT_CTRL_EN
  ,
  output logic [TAINT_W-1:0]         ctrl_taint
`endif
);

  logic [DATA_W-1:0]  a_arr  [NUM_REQ];
  logic [TAINT_W-1:0] t_arr  [NUM_REQ];
  logic [2:0]         op_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[gi*DATA_W +: DATA_W];
      assign t_arr[gi]  = req_a_t[gi*TAINT_W +: TAINT_W];
      assign op_arr[gi] = req_op[gi*3 +: 3];
    end
  endgenerate

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [TAINT_W-1:0] out_data_t_q, out_data_t_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  logic [2:0]         out_op_q, out_op_d;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping at NUM_REQ.
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   scan_w;
  logic [ID_W-1:0] scan_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_w      = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_w = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_w >= (ID_W+1)'(NUM_REQ)) begin
        scan_w = scan_w - (ID_W+1)'(NUM_REQ);
      end
      scan_idx = scan_w[ID_W-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  logic accept;
  assign accept    = grant_found && ((state_q == ST_IDLE) || out_ready);
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  logic [TAINT_W-1:0] ctrl_or;
`ifdef UNARY_IFT_SCHED_TAINT_CTRL_EN
  logic [TAINT_W-1:0] ctrl_taint_q, ctrl_taint_d;

  // Every contender influences who wins, so all their tags flow into the result.
  always_comb begin
    ctrl_or = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid[k]) begin
        ctrl_or = ctrl_or | t_arr[k];
      end
    end
  end
`else
  assign ctrl_or = '0;
`endif

  logic [DATA_W-1:0]  eval_y;
  logic [TAINT_W-1:0] eval_t;

  unary_ift_eval #(
    .DATA_W (DATA_W),
    .TAINT_W(TAINT_W)
  ) u_eval (
    .a     (a_arr[grant_idx]),
    .a_t   (t_arr[grant_idx]),
    .ctrl_t(ctrl_or),
    .op    (op_arr[grant_idx]),
    .y     (eval_y),
    .y_t   (eval_t)
  );

  logic [ID_W-1:0] ptr_after_grant;
  assign ptr_after_grant = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_data_t_d = out_data_t_q;
    out_id_d     = out_id_q;
    out_op_d     = out_op_q;
`ifdef UNARY_IFT_SCHED_TAINT_CTRL_EN
    ctrl_taint_d = ctrl_taint_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready && !accept) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = eval_y;
      out_data_t_d = eval_t;
      out_id_d     = grant_idx;
      out_op_d     = op_arr[grant_idx];
      rr_ptr_d     = ptr_after_grant;
`ifdef UNARY_IFT_SCHED_TAINT_CTRL_EN
      ctrl_taint_d = ctrl_or;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_data_t_q <= '0;
      out_id_q     <= '0;
      out_op_q     <= '0;
`ifdef UNARY_IFT_SCHED_TAINT_CTRL_EN
      ctrl_taint_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_data_t_q <= out_data_t_d;
      out_id_q     <= out_id_d;
      out_op_q     <= out_op_d;
`ifdef UNARY_IFT_SCHED_TAINT_CTRL_EN
      ctrl_taint_q <= ctrl_taint_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_data_t = out_data_t_q;
  assign out_id     = out_id_q;
  assign out_op     = out_op_q;
`ifdef UNARY_IFT_SCHED_TAINT_CTRL_EN
  assign ctrl_taint = ctrl_taint_q;
`endif

endmodule

// File: tb/tb_unary_ift_rr_scheduler.sv
// Directed self-checking bench for unary_ift_rr_scheduler (4 requesters, 8-bit data).
// Also covers ctrl_taint when UNARY_IFT_SCHED_TAINT_CTRL_EN is defined.
module tb_unary_ift_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TAINT_W = 32;
  localparam int ID_W    = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*DATA_W-1:0]  req_a;
  logic [NUM_REQ*TAINT_W-1:0] req_a_t;
  logic [NUM_REQ*3-1:0]       req_op;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic [TAINT_W-1:0]         out_data_t;
  logic [ID_W-1:0]            out_id;
  logic [2:0]                 out_op;
`ifdef UNARY_IFT_SCHED_TAINT_CTRL_EN
  logic [TAINT_W-1:0]         ctrl_taint;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  unary_ift_rr_scheduler #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .TAINT_W(TAINT_W),
    .ID_W   (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_a_t   (req_a_t),
    .req_op    (req_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_data_t(out_data_t),
    .out_id    (out_id),
    .out_op    (out_op)
`ifdef UNARY_IFT_SCHED_TAINT_CTRL_EN
    ,
    .ctrl_taint(ctrl_taint)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] t, input logic [2:0] op);
    req_a[i*DATA_W +: DATA_W]    = a;
    req_a_t[i*TAINT_W +: TAINT_W] = t;
    req_op[i*3 +: 3]             = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [2:0] op;
    logic [7:0] exp;
  } op_vec_t;

  op_vec_t op_tab [10];

  initial begin
    op_tab[0] = '{8'h80, 3'd2, 8'h80};
    op_tab[1] = '{8'h80, 3'd4, 8'h01};
    op_tab[2] = '{8'h80, 3'd6, 8'h00};
    op_tab[3] = '{8'h80, 3'd3, 8'h00};
    op_tab[4] = '{8'h80, 3'd5, 8'h01};
    op_tab[5] = '{8'h80, 3'd0, 8'h7F};
    op_tab[6] = '{8'h80, 3'd1, 8'h80};
    op_tab[7] = '{8'h00, 3'd7, 8'h01};
    op_tab[8] = '{8'h00, 3'd2, 8'h00};
    op_tab[9] = '{8'hFF, 3'd3, 8'h01};

    rst = 1'b1; req_valid = '0; req_a = '0; req_a_t = '0; req_op = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_data_t", 64'(out_data_t), 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    check("rst_out_op", 64'(out_op), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    $display("[TB] reset checked");

    // Round robin with all four requesters valid: grants 0,1,2,3,0.
    rst = 1'b0; out_ready = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'h10 + 8'(i), 32'h100 << i, 3'd1);
    #1;
    check("rr_ready0", 64'(req_ready), 64'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_valid", 64'(out_valid), 64'd1);
      check("rr_id", 64'(out_id), 64'(k % 4));
      check("rr_data", 64'(out_data), 64'(8'h10 + 8'(k % 4)));
      check("rr_taint", 64'(out_data_t), 64'(32'h100 << (k % 4)));
      if (k == 4) req_valid = '0;
      #1;
      check("rr_ready", 64'(req_ready), (k == 4) ? 64'd0 : 64'(4'b0001 << ((k + 1) % 4)));
      $display("[TB] rr grant %0d id=%0d data=%0h", k, out_id, out_data);
    end
    tick();
    check("rr_drain_valid", 64'(out_valid), 64'd0);

    // Single requester: not(0x0F) = 0xF0.
    req_valid = 4'b0001; set_req(0, 8'h0F, 32'h1, 3'd0);
    #1;
    check("single_ready", 64'(req_ready), 64'b0001);
    tick();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", 64'(out_data), 64'hF0);
    check("single_taint", 64'(out_data_t), 64'h1);
    check("single_id", 64'(out_id), 64'd0);
    check("single_op", 64'(out_op), 64'd0);
    $display("[TB] single id=%0d data=%0h taint=%0h", out_id, out_data, out_data_t);

    // Backpressure for 3 cycles, then zero-bubble accept of requester 1 (neg 0x33 = 0xCD).
    out_ready = 1'b0; req_valid = 4'b0110;
    set_req(1, 8'h33, 32'h2, 3'd2);
    set_req(2, 8'h44, 32'h3, 3'd1);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'hF0);
      check("bp_id", 64'(out_id), 64'd0);
      $display("[TB] backpressure cycle %0d data=%0h", k, out_data);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'b0010);
    tick();
    check("bp_next_id", 64'(out_id), 64'd1);
    check("bp_next_data", 64'(out_data), 64'hCD);
    check("bp_next_taint", 64'(out_data_t), 64'h2);
    check("bp_next_op", 64'(out_op), 64'd2);
    req_valid = '0;
    tick();
    check("bp_drain_valid", 64'(out_valid), 64'd0);

    // Opcode table on requester 3, back to back.
    req_valid = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      set_req(3, op_tab[k].a, 32'hDEADBEEF, op_tab[k].op);
      tick();
      check("op_valid", 64'(out_valid), 64'd1);
      check("op_data", 64'(out_data), 64'(op_tab[k].exp));
      check("op_taint", 64'(out_data_t), 64'hDEADBEEF);
      check("op_id", 64'(out_id), 64'd3);
      check("op_op", 64'(out_op), 64'(op_tab[k].op));
      $display("[TB] op %0d a=%0h data=%0h", op_tab[k].op, op_tab[k].a, out_data);
    end

    // Grant requester 1 so the pointer moves to 2, then reset while holding.
    req_valid = 4'b0010;
    tick();
    check("pre_rst_id", 64'(out_id), 64'd1);
    out_ready = 1'b0; req_valid = '0;
    tick();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0; out_ready = 1'b1; req_valid = 4'b1010;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'b0010);
    tick();
    check("post_rst_id", 64'(out_id), 64'd1);
    check("post_rst_data", 64'(out_data), 64'hCD);
    $display("[TB] post-reset grant id=%0d", out_id);

    // Two contenders: requester 0 wins from a fresh pointer.
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0; req_valid = 4'b0101;
    set_req(0, 8'h0F, 32'h1, 3'd0);
    set_req(2, 8'h55, 32'h4, 3'd1);
    #1;
    check("ctrl_ready", 64'(req_ready), 64'b0001);
    tick();
    check("ctrl_id", 64'(out_id), 64'd0);
`ifdef UNARY_IFT_SCHED_TAINT_CTRL_EN
    check("ctrl_out_taint", 64'(out_data_t), 64'h5);
    check("ctrl_taint", 64'(ctrl_taint), 64'h5);
`else
    check("ctrl_out_taint", 64'(out_data_t), 64'h1);
`endif
    $display("[TB] contention id=%0d taint=%0h", out_id, out_data_t);
    req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
